// File: rtl/eth_mac_rx_if.sv
// PHY receive signals and frame/status outputs of eth_mac_rx.
// The master modport is the PHY/consumer side, the slave modport is the MAC.
interface eth_mac_rx_if #(
    parameter int DATA_W = 4
) ();
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_er;
    logic [7:0]        data_out;
    logic              wr_en;
    logic              frame_done;
    logic              frame_valid;
    logic              frame_err;
    logic [2:0]        err_code;
    logic [10:0]       frame_len;

    modport master (
        output rx_data, rx_valid, rx_er,
        input  data_out, wr_en, frame_done, frame_valid, frame_err, err_code, frame_len
    );

    modport slave (
        input  rx_data, rx_valid, rx_er,
        output data_out, wr_en, frame_done, frame_valid, frame_err, err_code, frame_len
    );
endinterface

// File: rtl/eth_mac_rx.sv
// Ethernet MAC receiver: MII/GMII byte assembly, DA filter, FCS strip, CRC-32 check, status.
// Define ETH_RX_STATS_EN to build the good/error/drop statistics counters.
module eth_mac_rx #(
    parameter int          DATA_W        = 4,
    parameter logic [47:0] MAC_ADDR      = 48'h02_00_00_00_00_01,
    parameter bit          ACCEPT_BCAST  = 1'b1,
    parameter bit          PROMISC       = 1'b0,
    parameter int          MIN_FRAME_LEN = 64,
    parameter int          MAX_FRAME_LEN = 1518,
    parameter int          IFG_CYCLES    = 12
) (
    input  logic        rx_clk,
    input  logic        rst,
    eth_mac_rx_if.slave bus,
    output logic [15:0] rx_good_cnt,
    output logic [15:0] rx_err_cnt,
    output logic [15:0] rx_drop_cnt
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] PREAMBLE = 3'd1;
    localparam logic [2:0] HEADER   = 3'd2;
    localparam logic [2:0] PAYLOAD  = 3'd3;
    localparam logic [2:0] DROP     = 3'd4;
    localparam logic [2:0] DRAIN    = 3'd5;
    localparam logic [2:0] STATUS   = 3'd6;
    localparam logic [2:0] IFG      = 3'd7;

    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [10:0] MIN_LEN     = 11'(MIN_FRAME_LEN);
    localparam logic [10:0] MAX_LEN     = 11'(MAX_FRAME_LEN);
    localparam logic [15:0] IFG_LAST    = 16'(IFG_CYCLES - 1);

    logic [2:0]       state;
    logic             byte_stb;
    logic [7:0]       byte_val;
    logic             nib_phase;
    logic             armed;
    logic [5:0][7:0]  pipe;
    logic [10:0]      byte_cnt;
    logic [31:0]      crc;
    logic             rx_er_seen;
    logic             too_long;
    logic             odd_nib;
    logic             drain_cnt;
    logic [15:0]      ifg_cnt;
    logic             in_frame;
    logic             da_ok;
    logic             go_status;
    logic             drop_evt;
    logic             odd_now;
    logic [47:0]      da_bytes;
    logic [2:0]       err_now;

    // Reflected CRC-32 (poly 0x04C11DB7), one byte, LSB first as it comes off the wire.
    function automatic logic [31:0] crc_engine(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    generate
        if (DATA_W == 4) begin : g_mii
            logic [3:0] low_nib;
            always_ff @(posedge rx_clk or posedge rst) begin
                if (rst) begin
                    low_nib   <= '0;
                    nib_phase <= 1'b0;
                end else if (!bus.rx_valid) begin
                    nib_phase <= 1'b0;
                end else begin
                    nib_phase <= ~nib_phase;
                    if (!nib_phase)
                        low_nib <= bus.rx_data[3:0];
                end
            end
            assign byte_stb = bus.rx_valid && nib_phase;
            assign byte_val = {bus.rx_data[3:0], low_nib};
        end else if (DATA_W == 8) begin : g_gmii
            assign nib_phase = 1'b0;
            assign byte_stb  = bus.rx_valid;
            assign byte_val  = bus.rx_data[7:0];
        end else begin : g_bad_width
            $error("eth_mac_rx: DATA_W must be 4 or 8");
        end
    endgenerate

    // pipe[0] holds the newest byte, so at byte 5 the DA is pipe[4..0] plus the byte in hand.
    assign da_bytes  = {pipe[4], pipe[3], pipe[2], pipe[1], pipe[0], byte_val};
    assign da_ok     = PROMISC || (da_bytes == MAC_ADDR) ||
                       (ACCEPT_BCAST && (da_bytes == 48'hFFFF_FFFF_FFFF));
    assign in_frame  = (state == HEADER) || (state == PAYLOAD) || (state == DROP);
    assign odd_now   = odd_nib || (nib_phase && !bus.rx_valid);
    assign go_status = ((state == DRAIN) && drain_cnt) ||
                       ((state == DROP) && !bus.rx_valid && too_long);
    assign drop_evt  = (state == DROP) && !bus.rx_valid && !too_long;

    always_comb begin
        err_now = 3'd0;
        if (rx_er_seen)                       err_now = 3'd5;
        else if (odd_now)                     err_now = 3'd4;
        else if (too_long || byte_cnt > MAX_LEN) err_now = 3'd3;
        else if (byte_cnt < MIN_LEN)          err_now = 3'd2;
        else if (crc != CRC_RESIDUE)          err_now = 3'd1;
    end

    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            armed           <= 1'b0;
            pipe            <= '0;
            byte_cnt        <= '0;
            crc             <= '1;
            rx_er_seen      <= 1'b0;
            too_long        <= 1'b0;
            odd_nib         <= 1'b0;
            drain_cnt       <= 1'b0;
            ifg_cnt         <= '0;
            bus.data_out    <= '0;
            bus.wr_en       <= 1'b0;
            bus.frame_done  <= 1'b0;
            bus.frame_valid <= 1'b0;
            bus.frame_err   <= 1'b0;
            bus.err_code    <= '0;
            bus.frame_len   <= '0;
        end else begin
            bus.wr_en       <= 1'b0;
            bus.frame_done  <= 1'b0;
            bus.frame_valid <= 1'b0;
            bus.frame_err   <= 1'b0;
            if (!bus.rx_valid)
                armed <= 1'b1;
            if (state == PREAMBLE)
                crc <= '1;
            else if (byte_stb && in_frame)
                crc <= crc_engine(crc, byte_val);
            if (in_frame && bus.rx_valid && bus.rx_er)
                rx_er_seen <= 1'b1;

            case (state)
                IDLE: begin
                    if (armed && byte_stb && byte_val == 8'h55)
                        state <= PREAMBLE;
                end
                PREAMBLE: begin
                    if (!bus.rx_valid) begin
                        state <= IDLE;
                    end else if (byte_stb) begin
                        if (byte_val == 8'hD5) begin
                            state      <= HEADER;
                            byte_cnt   <= '0;
                            rx_er_seen <= 1'b0;
                            too_long   <= 1'b0;
                            odd_nib    <= 1'b0;
                        end else if (byte_val != 8'h55) begin
                            state <= IDLE;
                        end
                    end
                end
                // A frame shorter than 6 bytes never got its DA checked and vanishes silently.
                HEADER, PAYLOAD: begin
                    if (!bus.rx_valid) begin
                        odd_nib   <= nib_phase;
                        drain_cnt <= 1'b0;
                        state     <= (byte_cnt < 11'd6) ? IDLE : DRAIN;
                    end else if (byte_stb) begin
                        pipe     <= {pipe[4:0], byte_val};
                        byte_cnt <= byte_cnt + 11'd1;
                        if (byte_cnt >= MAX_LEN) begin
                            too_long <= 1'b1;
                            state    <= DROP;
                        end else begin
                            if (byte_cnt >= 11'd6) begin
                                bus.wr_en    <= 1'b1;
                                bus.data_out <= pipe[5];
                            end
                            if (byte_cnt == 11'd5 && !da_ok)
                                state <= DROP;
                            else if (byte_cnt == 11'd13)
                                state <= PAYLOAD;
                        end
                    end
                end
                DROP: begin
                    if (!bus.rx_valid) begin
                        state   <= too_long ? STATUS : IFG;
                        ifg_cnt <= '0;
                    end else if (byte_stb && byte_cnt != 11'h7FF) begin
                        byte_cnt <= byte_cnt + 11'd1;
                    end
                end
                // The last two payload bytes still sit at the old end; the other four are FCS.
                DRAIN: begin
                    bus.wr_en    <= 1'b1;
                    bus.data_out <= pipe[5];
                    pipe         <= {pipe[4:0], 8'h00};
                    drain_cnt    <= 1'b1;
                    if (drain_cnt)
                        state <= STATUS;
                end
                STATUS: begin
                    state   <= IFG;
                    ifg_cnt <= '0;
                end
                IFG: begin
                    if (ifg_cnt >= IFG_LAST)
                        state <= IDLE;
                    else
                        ifg_cnt <= ifg_cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase

            if (go_status) begin
                bus.frame_done  <= 1'b1;
                bus.frame_valid <= (err_now == 3'd0);
                bus.frame_err   <= (err_now != 3'd0);
                bus.err_code    <= err_now;
                bus.frame_len   <= byte_cnt;
            end
        end
    end

`ifdef ETH_RX_STATS_EN
    // Saturating statistics; the drop counter counts DA-rejected frames only.
    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            rx_good_cnt <= '0;
            rx_err_cnt  <= '0;
            rx_drop_cnt <= '0;
        end else begin
            if (bus.frame_valid && rx_good_cnt != 16'hFFFF)
                rx_good_cnt <= rx_good_cnt + 16'd1;
            if (bus.frame_err && rx_err_cnt != 16'hFFFF)
                rx_err_cnt <= rx_err_cnt + 16'd1;
            if (drop_evt && rx_drop_cnt != 16'hFFFF)
                rx_drop_cnt <= rx_drop_cnt + 16'd1;
        end
    end
`else
    assign rx_good_cnt = '0;
    assign rx_err_cnt  = '0;
    assign rx_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_eth_mac_rx.sv
// Directed bench for eth_mac_rx: an MII instance for the frame/error/reset cases and a GMII
// instance for the length limits; expected values are hand-derived frame facts.
module tb_eth_mac_rx;

    localparam logic [47:0] MAC = 48'h02_00_00_00_00_01;

    logic rx_clk = 1'b0;
    logic rst;
    always #5 rx_clk = ~rx_clk;

    eth_mac_rx_if #(.DATA_W(4)) bus4 ();
    eth_mac_rx_if #(.DATA_W(8)) bus8 ();
    logic [15:0] good4, errc4, drop4, good8, errc8, drop8;

    eth_mac_rx #(.DATA_W(4)) dut4 (
        .rx_clk(rx_clk), .rst(rst), .bus(bus4.slave),
        .rx_good_cnt(good4), .rx_err_cnt(errc4), .rx_drop_cnt(drop4)
    );

    eth_mac_rx #(.DATA_W(8)) dut8 (
        .rx_clk(rx_clk), .rst(rst), .bus(bus8.slave),
        .rx_good_cnt(good8), .rx_err_cnt(errc8), .rx_drop_cnt(drop8)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  frm  [0:2047];
    logic [7:0]  cap4 [0:2047];
    logic [7:0]  cap8 [0:2047];
    int          wr4, done4, wr8, done8;
    logic        fv4, fe4, fv8, fe8;
    logic [2:0]  ec4, ec8;
    logic [10:0] fl4, fl8;

    // Output monitors, sampled on the falling edge away from the DUT's active edge.
    always @(negedge rx_clk) begin
        if (bus4.wr_en) begin
            if (wr4 < 2048) cap4[wr4] = bus4.data_out;
            wr4++;
        end
        if (bus4.frame_done) begin
            done4++; fv4 = bus4.frame_valid; fe4 = bus4.frame_err;
            ec4 = bus4.err_code; fl4 = bus4.frame_len;
        end
        if (bus8.wr_en) begin
            if (wr8 < 2048) cap8[wr8] = bus8.data_out;
            wr8++;
        end
        if (bus8.frame_done) begin
            done8++; fv8 = bus8.frame_valid; fe8 = bus8.frame_err;
            ec8 = bus8.err_code; fl8 = bus8.frame_len;
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int stat(input int n);
`ifdef ETH_RX_STATS_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        c = '1;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 8; b++)
                c = (c[0] ^ frm[i][b]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return ~c;
    endfunction

    task automatic build_frame(input logic [47:0] da, input int len);
        logic [31:0] fcs;
        for (int i = 0; i < 6; i++) frm[i] = da[47-8*i -: 8];
        frm[6] = 8'h02; frm[7] = 8'hAA; frm[8] = 8'hBB;
        frm[9] = 8'hCC; frm[10] = 8'hDD; frm[11] = 8'hEE;
        frm[12] = 8'h08; frm[13] = 8'h00;
        for (int i = 14; i < len - 4; i++) frm[i] = 8'(i + 16);
        fcs = fcs_of(len - 4);
        frm[len-4] = fcs[7:0];   frm[len-3] = fcs[15:8];
        frm[len-2] = fcs[23:16]; frm[len-1] = fcs[31:24];
    endtask

    task automatic clear_mon();
        wr4 = 0; done4 = 0; fv4 = 0; fe4 = 0; ec4 = 0; fl4 = 0;
        wr8 = 0; done8 = 0; fv8 = 0; fe8 = 0; ec8 = 0; fl8 = 0;
    endtask

    task automatic send_byte4(input logic [7:0] b, input bit er);
        @(negedge rx_clk);
        bus4.rx_valid = 1'b1; bus4.rx_data = b[3:0]; bus4.rx_er = er;
        @(negedge rx_clk);
        bus4.rx_data = b[7:4]; bus4.rx_er = 1'b0;
    endtask

    task automatic end_frame4();
        @(negedge rx_clk);
        bus4.rx_valid = 1'b0; bus4.rx_data = '0; bus4.rx_er = 1'b0;
        repeat (30) @(negedge rx_clk);
    endtask

    task automatic send_frame4(input int n, input int er_at, input bit odd);
        for (int i = 0; i < 7; i++) send_byte4(8'h55, 1'b0);
        send_byte4(8'hD5, 1'b0);
        for (int i = 0; i < n; i++) send_byte4(frm[i], i == er_at);
        if (odd) begin
            @(negedge rx_clk);
            bus4.rx_data = 4'h7;
        end
        end_frame4();
    endtask

    task automatic send_frame8(input int n);
        for (int i = 0; i < 8; i++) begin
            @(negedge rx_clk);
            bus8.rx_valid = 1'b1; bus8.rx_data = (i == 7) ? 8'hD5 : 8'h55;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge rx_clk);
            bus8.rx_data = frm[i];
        end
        @(negedge rx_clk);
        bus8.rx_valid = 1'b0; bus8.rx_data = '0;
        repeat (30) @(negedge rx_clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus4.rx_valid = 1'b0; bus4.rx_data = '0; bus4.rx_er = 1'b0;
        bus8.rx_valid = 1'b0; bus8.rx_data = '0; bus8.rx_er = 1'b0;
        clear_mon();
        #1 rst = 1'b1;
        repeat (3) @(negedge rx_clk);
        total++;
        if ({bus4.wr_en, bus4.frame_done, bus4.frame_valid, bus4.frame_err} !== 4'b0000) begin
            bad++; $display("[TB] FAIL reset_strobes: got %b want 0000",
                {bus4.wr_en, bus4.frame_done, bus4.frame_valid, bus4.frame_err});
        end
        total++;
        if ({bus4.data_out, bus4.err_code, bus4.frame_len} !== 22'd0) begin
            bad++; $display("[TB] FAIL reset_data: got %h/%0d/%0d want 0/0/0",
                bus4.data_out, bus4.err_code, bus4.frame_len);
        end
        total++;
        if ({good4, errc4, drop4} !== 48'd0) begin
            bad++; $display("[TB] FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", good4, errc4, drop4);
        end
        total++;
        if ({bus8.wr_en, bus8.frame_done, bus8.frame_len} !== 13'd0) begin
            bad++; $display("[TB] FAIL reset_gmii: got %b/%b/%0d want 0/0/0",
                bus8.wr_en, bus8.frame_done, bus8.frame_len);
        end
        rst = 1'b0;
        repeat (4) @(negedge rx_clk);
    endtask

    task automatic test_good_frame();
        int miss;
        build_frame(MAC, 64);
        clear_mon();
        send_frame4(64, -1, 1'b0);
        miss = 0;
        for (int i = 0; i < 60; i++) if (cap4[i] !== frm[i]) miss++;
        total++; if (wr4 !== 60) begin bad++; $display("[TB] FAIL good_wr_count: got %0d want 60", wr4); end
        total++; if (miss !== 0) begin bad++; $display("[TB] FAIL good_data: got %0d bad bytes want 0", miss); end
        total++; if (done4 !== 1) begin bad++; $display("[TB] FAIL good_done: got %0d want 1", done4); end
        total++;
        if ({fv4, fe4, ec4} !== 5'b10_000) begin
            bad++; $display("[TB] FAIL good_status: got v=%b e=%b code=%0d want v=1 e=0 code=0", fv4, fe4, ec4);
        end
        total++; if (fl4 !== 11'd64) begin bad++; $display("[TB] FAIL good_len: got %0d want 64", fl4); end
        total++;
        if (good4 !== 16'(stat(1))) begin bad++; $display("[TB] FAIL good_cnt: got %0d want %0d", good4, stat(1)); end
    endtask

    task automatic test_bad_crc();
        int miss;
        build_frame(MAC, 64);
        frm[30] = frm[30] ^ 8'h04;
        clear_mon();
        send_frame4(64, -1, 1'b0);
        miss = 0;
        for (int i = 0; i < 60; i++) if (cap4[i] !== frm[i]) miss++;
        total++; if (wr4 !== 60) begin bad++; $display("[TB] FAIL crc_wr_count: got %0d want 60", wr4); end
        total++; if (miss !== 0) begin bad++; $display("[TB] FAIL crc_data: got %0d bad bytes want 0", miss); end
        total++;
        if ({done4 == 1, fv4, fe4, ec4} !== 6'b1_01_001) begin
            bad++; $display("[TB] FAIL crc_status: got done=%0d v=%b e=%b code=%0d want done=1 v=0 e=1 code=1",
                done4, fv4, fe4, ec4);
        end
    endtask

    task automatic test_rx_er();
        build_frame(MAC, 64);
        frm[40] = frm[40] ^ 8'h01;
        clear_mon();
        send_frame4(64, 35, 1'b0);
        total++; if (wr4 !== 60) begin bad++; $display("[TB] FAIL rxer_wr_count: got %0d want 60", wr4); end
        total++;
        if ({done4 == 1, fe4, ec4} !== 5'b1_1_101) begin
            bad++; $display("[TB] FAIL rxer_status: got done=%0d e=%b code=%0d want done=1 e=1 code=5", done4, fe4, ec4);
        end
    endtask

    task automatic test_odd_nibble();
        build_frame(MAC, 64);
        clear_mon();
        send_frame4(64, -1, 1'b1);
        total++;
        if ({done4 == 1, fe4, ec4, fl4} !== {1'b1, 1'b1, 3'd4, 11'd64}) begin
            bad++; $display("[TB] FAIL odd_status: got done=%0d e=%b code=%0d len=%0d want done=1 e=1 code=4 len=64",
                done4, fe4, ec4, fl4);
        end
        total++;
        if (errc4 !== 16'(stat(3))) begin bad++; $display("[TB] FAIL err_cnt: got %0d want %0d", errc4, stat(3)); end
    endtask

    task automatic test_reject_da();
        build_frame(48'h02_00_00_00_00_02, 64);
        clear_mon();
        send_frame4(64, -1, 1'b0);
        total++; if (wr4 !== 0) begin bad++; $display("[TB] FAIL reject_wr_count: got %0d want 0", wr4); end
        total++; if (done4 !== 0) begin bad++; $display("[TB] FAIL reject_done: got %0d want 0", done4); end
        total++;
        if (drop4 !== 16'(stat(1))) begin bad++; $display("[TB] FAIL drop_cnt: got %0d want %0d", drop4, stat(1)); end
    endtask

    task automatic test_runt();
        build_frame(MAC, 64);
        clear_mon();
        send_frame4(4, -1, 1'b0);
        total++;
        if (wr4 !== 0 || done4 !== 0) begin
            bad++; $display("[TB] FAIL runt_silent: got wr=%0d done=%0d want wr=0 done=0", wr4, done4);
        end
    endtask

    task automatic test_reset_mid_frame();
        build_frame(MAC, 64);
        clear_mon();
        for (int i = 0; i < 7; i++) send_byte4(8'h55, 1'b0);
        send_byte4(8'hD5, 1'b0);
        for (int i = 0; i < 30; i++) send_byte4(frm[i], 1'b0);
        @(negedge rx_clk);
        bus4.rx_data = 4'hC;
        rst = 1'b1;
        #1;
        total++;
        if ({bus4.wr_en, bus4.frame_done, bus4.data_out, bus4.err_code, bus4.frame_len} !== 24'd0) begin
            bad++; $display("[TB] FAIL midreset_outputs: got wr=%b done=%b d=%h code=%0d len=%0d want all 0",
                bus4.wr_en, bus4.frame_done, bus4.data_out, bus4.err_code, bus4.frame_len);
        end
        total++;
        if ({good4, errc4, drop4} !== 48'd0) begin
            bad++; $display("[TB] FAIL midreset_counters: got %0d/%0d/%0d want 0/0/0", good4, errc4, drop4);
        end
        repeat (3) @(negedge rx_clk);
        rst = 1'b0;
        clear_mon();
        // A complete frame follows with rx_valid never dropping, so it must stay unseen.
        for (int i = 0; i < 7; i++) send_byte4(8'h55, 1'b0);
        send_byte4(8'hD5, 1'b0);
        for (int i = 0; i < 64; i++) send_byte4(frm[i], 1'b0);
        end_frame4();
        total++;
        if (wr4 !== 0 || done4 !== 0) begin
            bad++; $display("[TB] FAIL midreset_ignored: got wr=%0d done=%0d want wr=0 done=0", wr4, done4);
        end
        clear_mon();
        send_frame4(64, -1, 1'b0);
        total++;
        if ({wr4 == 60, done4 == 1, fv4, ec4} !== 6'b1_1_1_000) begin
            bad++; $display("[TB] FAIL midreset_next: got wr=%0d done=%0d v=%b code=%0d want wr=60 done=1 v=1 code=0",
                wr4, done4, fv4, ec4);
        end
        total++;
        if (good4 !== 16'(stat(1)) || drop4 !== 16'd0) begin
            bad++; $display("[TB] FAIL midreset_cnts: got good=%0d drop=%0d want good=%0d drop=0", good4, drop4, stat(1));
        end
    endtask

    task automatic test_long_frame();
        int miss;
        build_frame(MAC, 1600);
        clear_mon();
        send_frame8(1600);
        miss = 0;
        for (int i = 0; i < 1512; i++) if (cap8[i] !== frm[i]) miss++;
        total++; if (wr8 !== 1512) begin bad++; $display("[TB] FAIL long_wr_count: got %0d want 1512", wr8); end
        total++; if (miss !== 0) begin bad++; $display("[TB] FAIL long_data: got %0d bad bytes want 0", miss); end
        total++;
        if ({done8 == 1, fv8, fe8, ec8} !== 6'b1_01_011) begin
            bad++; $display("[TB] FAIL long_status: got done=%0d v=%b e=%b code=%0d want done=1 v=0 e=1 code=3",
                done8, fv8, fe8, ec8);
        end
        total++; if (fl8 !== 11'd1600) begin bad++; $display("[TB] FAIL long_len: got %0d want 1600", fl8); end
    endtask

    task automatic test_short_frame();
        build_frame(MAC, 40);
        clear_mon();
        send_frame8(40);
        total++; if (wr8 !== 36) begin bad++; $display("[TB] FAIL short_wr_count: got %0d want 36", wr8); end
        total++;
        if ({done8 == 1, fe8, ec8, fl8} !== {1'b1, 1'b1, 3'd2, 11'd40}) begin
            bad++; $display("[TB] FAIL short_status: got done=%0d e=%b code=%0d len=%0d want done=1 e=1 code=2 len=40",
                done8, fe8, ec8, fl8);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_crc();
        test_rx_er();
        test_odd_nibble();
        test_reject_da();
        test_runt();
        test_reset_mid_frame();
        test_long_frame();
        test_short_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
